// File: rtl/npu_load_buffer.sv
// npu_load_buffer: lands framed weight/data streams into two buffers
// and serves each held frame to the NPU core as a random-access read port.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   wt_sop/eop/vld/data  weight stream in (no backpressure)
//   wt_ready, wt_len     weight frame held, and its word count
//   wt_rd_en/addr/data   weight read port, 1-cycle latency
//   wt_release           frees the held weight frame
//   dt_*                 same set for the data stream/buffer
//   err_flags            sticky: [0] wt proto [1] wt ovf [2] dt proto [3] dt ovf
//   err_clr              clears err_flags and err_cnt
//   err_cnt              error-cycle counter, saturating at 255
//
// Optional feature: define NPU_LOAD_BUF_ERR_CNT_EN to build the error
// counter; otherwise err_cnt is tied to 0.

module npu_load_buffer_chan #(
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rel,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic              o_ready,
  output logic [AW:0]       o_len,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_perr,
  output logic              o_oerr
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FULL
  } st_t;

  st_t               r_st;
  logic [AW:0]       r_ptr;
  logic [AW:0]       r_len;
  logic              r_ready;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic        w_idle_like;
  logic        w_open;
  logic [AW:0] w_base;
  logic        w_acc;
  logic [AW:0] w_nptr;
  logic        w_hold;

  // w_idle_like: a released FULL buffer behaves as IDLE this cycle.
  // w_open: the cycle belongs to a frame (continuation or sop start).
  always_comb begin
    w_idle_like = (r_st == IDLE) | ((r_st == FULL) & i_rel);
    w_hold      = (r_st == FULL) & ~i_rel;
    w_open      = (r_st == RECV) | (w_idle_like & i_sop);
    w_base      = i_sop ? '0 : r_ptr;
    // base never exceeds DEPTH, so its MSB flags "buffer full"
    w_acc       = w_open & i_vld & ~w_base[AW];
    w_nptr      = w_base + {{AW{1'b0}}, w_acc};
    o_oerr      = w_open & i_vld & ~w_acc;
    o_perr      = (w_idle_like & ~i_sop & (i_vld | i_eop))
                | (w_hold & (i_sop | i_vld | i_eop))
                | ((r_st == RECV) & i_sop)
                | (w_open & i_eop & (w_nptr == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_ready <= 1'b0;
    end else if (w_open) begin
      if (i_eop && (w_nptr != '0)) begin
        r_st    <= FULL;
        r_ptr   <= w_nptr;
        r_len   <= w_nptr;
        r_ready <= 1'b1;
      end else if (i_eop) begin
        r_st    <= IDLE;
        r_ptr   <= '0;
        r_ready <= 1'b0;
      end else begin
        r_st    <= RECV;
        r_ptr   <= w_nptr;
        r_ready <= 1'b0;
      end
    end else if (w_idle_like) begin
      r_st    <= IDLE;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mem[w_base[AW-1:0]] <= i_data;
    end
  end

  // read-before-write: same-address collisions return old content
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_ready   = r_ready;
  assign o_len     = r_len;
  assign o_rd_data = r_rd_data;

endmodule

module npu_load_buffer #(
  parameter int DATA_W = 32,
  parameter int W_AW   = 8,
  parameter int D_AW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wt_sop,
  input  logic              wt_eop,
  input  logic              wt_vld,
  input  logic [DATA_W-1:0] wt_data,
  input  logic              dt_sop,
  input  logic              dt_eop,
  input  logic              dt_vld,
  input  logic [DATA_W-1:0] dt_data,
  output logic              wt_ready,
  output logic [W_AW:0]     wt_len,
  input  logic              wt_rd_en,
  input  logic [W_AW-1:0]   wt_rd_addr,
  output logic [DATA_W-1:0] wt_rd_data,
  input  logic              wt_release,
  output logic              dt_ready,
  output logic [D_AW:0]     dt_len,
  input  logic              dt_rd_en,
  input  logic [D_AW-1:0]   dt_rd_addr,
  output logic [DATA_W-1:0] dt_rd_data,
  input  logic              dt_release,
  output logic [3:0]        err_flags,
  input  logic              err_clr,
  output logic [7:0]        err_cnt
);

  logic       w_wt_perr;
  logic       w_wt_oerr;
  logic       w_dt_perr;
  logic       w_dt_oerr;
  logic [3:0] w_ev;
  logic [3:0] r_flags;

  npu_load_buffer_chan #(
    .DATA_W (DATA_W),
    .AW     (W_AW)
  ) u_wt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sop     (wt_sop),
    .i_eop     (wt_eop),
    .i_vld     (wt_vld),
    .i_data    (wt_data),
    .i_rel     (wt_release),
    .i_rd_en   (wt_rd_en),
    .i_rd_addr (wt_rd_addr),
    .o_ready   (wt_ready),
    .o_len     (wt_len),
    .o_rd_data (wt_rd_data),
    .o_perr    (w_wt_perr),
    .o_oerr    (w_wt_oerr)
  );

  npu_load_buffer_chan #(
    .DATA_W (DATA_W),
    .AW     (D_AW)
  ) u_dt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sop     (dt_sop),
    .i_eop     (dt_eop),
    .i_vld     (dt_vld),
    .i_data    (dt_data),
    .i_rel     (dt_release),
    .i_rd_en   (dt_rd_en),
    .i_rd_addr (dt_rd_addr),
    .o_ready   (dt_ready),
    .o_len     (dt_len),
    .o_rd_data (dt_rd_data),
    .o_perr    (w_dt_perr),
    .o_oerr    (w_dt_oerr)
  );

  assign w_ev = {w_dt_oerr, w_dt_perr, w_wt_oerr, w_wt_perr};

  // set has priority over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else begin
      r_flags <= (err_clr ? 4'b0 : r_flags) | w_ev;
    end
  end

  assign err_flags = r_flags;

`ifdef NPU_LOAD_BUF_ERR_CNT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (err_clr) begin
      r_cnt <= '0;
    end else if ((|w_ev) && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign err_cnt = r_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_npu_load_buffer.sv
// tb_npu_load_buffer: directed + random stimulus against a
// frame-level reference model of both landing buffers.

module tb_npu_load_buffer;

  localparam int DW = 32;
  localparam int WA = 2;
  localparam int DA = 3;

  logic          clk;
  logic          rst_n;
  logic          wt_sop, wt_eop, wt_vld;
  logic [DW-1:0] wt_data;
  logic          dt_sop, dt_eop, dt_vld;
  logic [DW-1:0] dt_data;
  logic          wt_ready;
  logic [WA:0]   wt_len;
  logic          wt_rd_en;
  logic [WA-1:0] wt_rd_addr;
  logic [DW-1:0] wt_rd_data;
  logic          wt_release;
  logic          dt_ready;
  logic [DA:0]   dt_len;
  logic          dt_rd_en;
  logic [DA-1:0] dt_rd_addr;
  logic [DW-1:0] dt_rd_data;
  logic          dt_release;
  logic [3:0]    err_flags;
  logic          err_clr;
  logic [7:0]    err_cnt;

  npu_load_buffer #(
    .DATA_W (DW),
    .W_AW   (WA),
    .D_AW   (DA)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wt_sop     (wt_sop),
    .wt_eop     (wt_eop),
    .wt_vld     (wt_vld),
    .wt_data    (wt_data),
    .dt_sop     (dt_sop),
    .dt_eop     (dt_eop),
    .dt_vld     (dt_vld),
    .dt_data    (dt_data),
    .wt_ready   (wt_ready),
    .wt_len     (wt_len),
    .wt_rd_en   (wt_rd_en),
    .wt_rd_addr (wt_rd_addr),
    .wt_rd_data (wt_rd_data),
    .wt_release (wt_release),
    .dt_ready   (dt_ready),
    .dt_len     (dt_len),
    .dt_rd_en   (dt_rd_en),
    .dt_rd_addr (dt_rd_addr),
    .dt_rd_data (dt_rd_data),
    .dt_release (dt_release),
    .err_flags  (err_flags),
    .err_clr    (err_clr),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: mode 0 = no frame, 1 = collecting, 2 = frame held
  int          md   [2];
  int          fcnt [2];
  int          flen [2];
  logic [31:0] fbuf [2][64];
  logic [31:0] erd  [2];
  bit          erd_ok [2];
  logic [3:0]  eflg;
  int          ecnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      md[c] = 0; fcnt[c] = 0; flen[c] = 0;
      erd[c] = '0; erd_ok[c] = 1'b1;
    end
    eflg = '0;
    ecnt = 0;
  endtask

  task automatic ch_step(input int c,
                         input logic s, input logic e,
                         input logic v, input logic [31:0] d,
                         input logic rel, input logic rde,
                         input int addr,
                         output logic pe, output logic oe);
    int dep;
    dep = (c == 0) ? (1 << WA) : (1 << DA);
    pe = 1'b0;
    oe = 1'b0;
    if (rde) begin
      erd_ok[c] = (md[c] == 2) && (addr < flen[c]);
      if (erd_ok[c]) erd[c] = fbuf[c][addr];
    end
    if (md[c] == 2 && !rel) begin
      pe = s | v | e;
    end else if (md[c] != 1 && !s) begin
      pe = v | e;
      md[c] = 0;
    end else begin
      if (md[c] == 1 && s) pe = 1'b1;
      if (s) fcnt[c] = 0;
      if (v) begin
        if (fcnt[c] < dep) begin
          fbuf[c][fcnt[c]] = d;
          fcnt[c]++;
        end else begin
          oe = 1'b1;
        end
      end
      if (e) begin
        if (fcnt[c] > 0) begin
          md[c] = 2;
          flen[c] = fcnt[c];
        end else begin
          md[c] = 0;
          pe = 1'b1;
        end
      end else begin
        md[c] = 1;
      end
    end
  endtask

  task automatic model_step();
    logic pe0, oe0, pe1, oe1;
    logic [3:0] ev;
    ch_step(0, wt_sop, wt_eop, wt_vld, wt_data, wt_release,
            wt_rd_en, int'(wt_rd_addr), pe0, oe0);
    ch_step(1, dt_sop, dt_eop, dt_vld, dt_data, dt_release,
            dt_rd_en, int'(dt_rd_addr), pe1, oe1);
    ev = {oe1, pe1, oe0, pe0};
    eflg = (err_clr ? 4'b0 : eflg) | ev;
`ifdef NPU_LOAD_BUF_ERR_CNT_EN
    if (err_clr) ecnt = 0;
    else if (ev != 0 && ecnt < 255) ecnt++;
`endif
  endtask

  task automatic compare();
    chk("wt_ready", 32'(wt_ready), 32'(md[0] == 2));
    chk("dt_ready", 32'(dt_ready), 32'(md[1] == 2));
    if (md[0] == 2) chk("wt_len", 32'(wt_len), 32'(flen[0]));
    if (md[1] == 2) chk("dt_len", 32'(dt_len), 32'(flen[1]));
    chk("err_flags", 32'(err_flags), 32'(eflg));
    chk("err_cnt", 32'(err_cnt), 32'(ecnt));
    if (erd_ok[0]) chk("wt_rd_data", wt_rd_data, erd[0]);
    if (erd_ok[1]) chk("dt_rd_data", dt_rd_data, erd[1]);
  endtask

  task automatic zero();
    wt_sop = 0; wt_eop = 0; wt_vld = 0; wt_data = '0;
    dt_sop = 0; dt_eop = 0; dt_vld = 0; dt_data = '0;
    wt_release = 0; dt_release = 0;
    wt_rd_en = 0; wt_rd_addr = '0;
    dt_rd_en = 0; dt_rd_addr = '0;
    err_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    zero();
  endtask

  task automatic wt(input logic s, input logic e,
                    input logic v, input logic [31:0] d);
    wt_sop = s; wt_eop = e; wt_vld = v; wt_data = d;
  endtask

  task automatic dt(input logic s, input logic e,
                    input logic v, input logic [31:0] d);
    dt_sop = s; dt_eop = e; dt_vld = v; dt_data = d;
  endtask

  initial begin
    zero();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_wt_ready", 32'(wt_ready), 32'd0);
    chk("rst_dt_ready", 32'(dt_ready), 32'd0);
    chk("rst_wt_len", 32'(wt_len), 32'd0);
    chk("rst_dt_len", 32'(dt_len), 32'd0);
    chk("rst_wt_rd", wt_rd_data, 32'd0);
    chk("rst_dt_rd", dt_rd_data, 32'd0);
    chk("rst_flags", 32'(err_flags), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;

    // four-word weight frame
    for (int i = 0; i < 4; i++) begin
      wt(i == 0, i == 3, 1'b1, 32'h11 * (i + 1));
      step();
    end
    chk("wt4_ready", 32'(wt_ready), 32'd1);
    chk("wt4_len", 32'(wt_len), 32'd4);
    for (int i = 0; i < 4; i++) begin
      wt_rd_en = 1'b1;
      wt_rd_addr = WA'(i);
      step();
      chk("wt4_rd", wt_rd_data, 32'h11 * (i + 1));
    end
    chk("wt4_flags", 32'(err_flags), 32'd0);
    wt_release = 1'b1;
    step();

    // single-word data frame
    dt(1'b1, 1'b1, 1'b1, 32'hA5);
    step();
    chk("dt1_len", 32'(dt_len), 32'd1);
    dt_rd_en = 1'b1;
    step();
    chk("dt1_rd", dt_rd_data, 32'hA5);
    dt_release = 1'b1;
    step();
    chk("dt1_rel", 32'(dt_ready), 32'd0);

    // six words into a four-deep weight buffer
    for (int i = 0; i < 6; i++) begin
      wt(i == 0, i == 5, 1'b1, 32'h101 + i);
      step();
    end
    chk("ovf_len", 32'(wt_len), 32'd4);
    chk("ovf_flag", 32'(err_flags[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wt_rd_en = 1'b1;
      wt_rd_addr = WA'(i);
      step();
    end
    err_clr = 1'b1;
    step();
    chk("ovf_clr", 32'(err_flags), 32'd0);

    // traffic into a held buffer, then release with a new sop
    wt(1'b1, 1'b0, 1'b1, 32'h55);
    step();
    chk("full_perr", 32'(err_flags[0]), 32'd1);
    chk("full_len", 32'(wt_len), 32'd4);
    wt(1'b1, 1'b0, 1'b1, 32'h77);
    wt_release = 1'b1;
    wt_rd_en = 1'b1;
    step();
    chk("rel_sop_rdy", 32'(wt_ready), 32'd0);
    wt(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk("rel_sop_len", 32'(wt_len), 32'd1);
    wt_rd_en = 1'b1;
    step();
    chk("rel_sop_rd", wt_rd_data, 32'h77);
    wt_release = 1'b1;
    err_clr = 1'b1;
    step();

    // interleaved 3-word weight and 5-word data frames
    for (int i = 0; i < 5; i++) begin
      if (i < 3) wt(i == 0, i == 2, 1'b1, 32'hC0 + i);
      dt(i == 0, i == 4, 1'b1, 32'hD0 + i);
      step();
    end
    chk("il_wt_len", 32'(wt_len), 32'd3);
    chk("il_dt_len", 32'(dt_len), 32'd5);
    for (int i = 0; i < 5; i++) begin
      wt_rd_en = 1'b1;
      wt_rd_addr = WA'(i % 3);
      dt_rd_en = 1'b1;
      dt_rd_addr = DA'(i);
      step();
      chk("il_dt_rd", dt_rd_data, 32'hD0 + i);
    end
    wt_release = 1'b1;
    dt_release = 1'b1;
    err_clr = 1'b1;
    step();
    dt_vld = 1'b1;
    step();
    chk("dt_idle_vld", 32'(err_flags), 32'h4);

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      dt_vld = 1'b1;
      step();
    end
`ifdef NPU_LOAD_BUF_ERR_CNT_EN
    chk("cnt_sat", 32'(err_cnt), 32'd255);
`else
    chk("cnt_off", 32'(err_cnt), 32'd0);
`endif
    err_clr = 1'b1;
    step();
    chk("cnt_clr", 32'(err_cnt), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      wt_sop = ($urandom_range(7) == 0);
      wt_eop = ($urandom_range(5) == 0);
      wt_vld = ($urandom_range(1) == 0);
      wt_data = $urandom;
      wt_release = ($urandom_range(5) == 0);
      wt_rd_en = ($urandom_range(1) == 0);
      wt_rd_addr = WA'($urandom_range((1 << WA) - 1));
      dt_sop = ($urandom_range(9) == 0);
      dt_eop = ($urandom_range(7) == 0);
      dt_vld = ($urandom_range(2) != 0);
      dt_data = $urandom;
      dt_release = ($urandom_range(5) == 0);
      dt_rd_en = ($urandom_range(1) == 0);
      dt_rd_addr = DA'($urandom_range((1 << DA) - 1));
      err_clr = ($urandom_range(19) == 0);
      step();
    end

    // reset in the middle of a frame
    wt_release = 1'b1;
    dt_release = 1'b1;
    step();
    wt(1'b1, 1'b0, 1'b1, 32'h99);
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_rdy", 32'(wt_ready), 32'd0);
    chk("mid_rst_flags", 32'(err_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wt(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk("mid_rst_eop", 32'(err_flags), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
